// File: rtl/rom_dl_pkg.sv
// Shared types and constants for the ROM download packer.
package rom_dl_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } wstate_e;

   localparam logic [7:0]  PAD            = 8'hFF;
   localparam int unsigned ADDR_W_DEF     = 25;
   localparam int unsigned FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/rom_dl_packer_if.sv
// Byte-stream input and SDRAM word-write handshake seen by the ROM download packer.
interface rom_dl_packer_if #(
   parameter int unsigned ADDR_W = 25
) ();
   import rom_dl_pkg::*;

   logic              ioctl_wr;
   logic [ADDR_W-1:0] ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              sdr_we;
   logic [ADDR_W-2:0] sdr_addr;
   word_t             sdr_din;
   logic              sdr_ack;

   modport master (
      input  ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
      output sdr_we, sdr_addr, sdr_din
   );

   modport slave (
      output ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
      input  sdr_we, sdr_addr, sdr_din
   );

endinterface

// File: rtl/rom_dl_fifo.sv
// Word FIFO holding data plus word address; wrap-bit pointers, synchronous clear,
// and push accepted on full when a pop happens in the same cycle.
module rom_dl_fifo
   import rom_dl_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  word_t         push_data,
   input  logic [AW-1:0] push_addr,
   input  logic          pop,
   output word_t         head_data_c,
   output logic [AW-1:0] head_addr_c,
   output logic          full_c,
   output logic          empty_c,
   output logic          empty_nxt_c
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned PW = IW + 1;

   word_t         data_mem [DEPTH];
   logic [AW-1:0] addr_mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW-1:0] wr_base, rd_base, wr_nxt, rd_nxt;
   logic          do_push, do_pop, full_base;

   assign empty_c     = (wr_ptr == rd_ptr);
   assign full_c      = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
   assign head_data_c = data_mem[rd_ptr[IW-1:0]];
   assign head_addr_c = addr_mem[rd_ptr[IW-1:0]];
   assign empty_nxt_c = (wr_nxt == rd_nxt);

   // A clear empties the FIFO first; a push in the same cycle lands in slot 0.
   always_comb begin
      wr_base   = clr ? '0 : wr_ptr;
      rd_base   = clr ? '0 : rd_ptr;
      do_pop    = pop && !empty_c && !clr;
      full_base = full_c && !clr;
      do_push   = push && (!full_base || do_pop);
      wr_nxt    = do_push ? wr_base + PW'(1) : wr_base;
      rd_nxt    = do_pop  ? rd_base + PW'(1) : rd_base;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         data_mem[wr_base[IW-1:0]] <= push_data;
         addr_mem[wr_base[IW-1:0]] <= push_addr;
      end
   end

endmodule

// File: rtl/rom_dl_packer.sv
// Packs ioctl download bytes into big-endian 16-bit words and writes them to SDRAM over req/ack.
// Define ROM_DL_CHECKSUM_EN to add a running sum of acknowledged words on port checksum.
module rom_dl_packer
   import rom_dl_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter logic [7:0]  PAD_BYTE   = PAD
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              rom_download,
   rom_dl_packer_if.master   bus,
   output logic              rom_loaded,
   output logic              overflow,
   output logic              busy
`ifdef ROM_DL_CHECKSUM_EN
   ,
   output word_t             checksum
`endif
);
   localparam int unsigned WA_W = ADDR_W - 1;

   wstate_e         state, state_n;
   logic            dl_q, dl_rise, dl_fall, dl_seen;
   logic            pend_valid, pend_valid_n;
   logic [7:0]      pend_byte, pend_byte_n;
   logic [WA_W-1:0] pend_addr, pend_addr_n;
   logic [WA_W-1:0] byte_waddr;

   logic            push, pop, overflow_set;
   word_t           push_data;
   logic [WA_W-1:0] push_addr;
   word_t           head_data;
   logic [WA_W-1:0] head_addr;
   logic            fifo_full, fifo_empty, fifo_empty_nxt;

   logic            sdr_we_q, sdr_we_n;
   logic [WA_W-1:0] sdr_addr_q, sdr_addr_n;
   word_t           sdr_din_q, sdr_din_n;

   assign dl_rise    = rom_download && !dl_q;
   assign dl_fall    = !rom_download && dl_q;
   assign byte_waddr = bus.ioctl_addr[ADDR_W-1:1];

   assign bus.sdr_we   = sdr_we_q;
   assign bus.sdr_addr = sdr_addr_q;
   assign bus.sdr_din  = sdr_din_q;

   // Byte packer: even byte waits in the pending slot, odd byte completes or is padded.
   always_comb begin
      push         = 1'b0;
      push_data    = '0;
      push_addr    = '0;
      pend_valid_n = pend_valid;
      pend_byte_n  = pend_byte;
      pend_addr_n  = pend_addr;
      if (dl_rise) pend_valid_n = 1'b0;
      if (bus.ioctl_wr) begin
         if (!bus.ioctl_addr[0]) begin
            if (pend_valid && !dl_rise) begin
               push      = 1'b1;
               push_data = {pend_byte, PAD_BYTE};
               push_addr = pend_addr;
            end
            pend_valid_n = 1'b1;
            pend_byte_n  = bus.ioctl_dout;
            pend_addr_n  = byte_waddr;
         end else if (pend_valid && !dl_rise && (pend_addr == byte_waddr)) begin
            push         = 1'b1;
            push_data    = {pend_byte, bus.ioctl_dout};
            push_addr    = pend_addr;
            pend_valid_n = 1'b0;
         end else begin
            push      = 1'b1;
            push_data = {PAD_BYTE, bus.ioctl_dout};
            push_addr = byte_waddr;
         end
      end else if (dl_fall && pend_valid) begin
         push         = 1'b1;
         push_data    = {pend_byte, PAD_BYTE};
         push_addr    = pend_addr;
         pend_valid_n = 1'b0;
      end
   end

   rom_dl_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (WA_W)
   ) u_fifo (
      .clk         (clk_sys),
      .rst         (reset),
      .clr         (dl_rise),
      .push        (push),
      .push_data   (push_data),
      .push_addr   (push_addr),
      .pop         (pop),
      .head_data_c (head_data),
      .head_addr_c (head_addr),
      .full_c      (fifo_full),
      .empty_c     (fifo_empty),
      .empty_nxt_c (fifo_empty_nxt)
   );

   assign overflow_set = push && fifo_full && !pop && !dl_rise;

   // Write FSM: a download start never pops, but an outstanding write still waits for its ack.
   always_comb begin
      state_n    = state;
      sdr_we_n   = sdr_we_q;
      sdr_addr_n = sdr_addr_q;
      sdr_din_n  = sdr_din_q;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && !dl_rise) begin
               pop        = 1'b1;
               sdr_we_n   = 1'b1;
               sdr_addr_n = head_addr;
               sdr_din_n  = head_data;
               state_n    = WAIT;
            end
         end
         WAIT: begin
            if (bus.sdr_ack) begin
               sdr_we_n = 1'b0;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sdr_we_q   <= 1'b0;
         sdr_addr_q <= '0;
         sdr_din_q  <= '0;
         pend_valid <= 1'b0;
         pend_byte  <= '0;
         pend_addr  <= '0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         sdr_we_q   <= sdr_we_n;
         sdr_addr_q <= sdr_addr_n;
         sdr_din_q  <= sdr_din_n;
         pend_valid <= pend_valid_n;
         pend_byte  <= pend_byte_n;
         pend_addr  <= pend_addr_n;
         busy       <= pend_valid_n || !fifo_empty_nxt || sdr_we_n;
      end
   end

   // Sticky status flags, reopened by each new download.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         dl_q       <= 1'b0;
         dl_seen    <= 1'b0;
         rom_loaded <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         dl_q <= rom_download;
         if (dl_rise) begin
            dl_seen    <= 1'b1;
            rom_loaded <= 1'b0;
            overflow   <= 1'b0;
         end else begin
            if (overflow_set) overflow <= 1'b1;
            if (!rom_download && fifo_empty && !pend_valid && (state == IDLE) && dl_seen)
               rom_loaded <= 1'b1;
         end
      end
   end

`ifdef ROM_DL_CHECKSUM_EN
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset)                                  checksum <= '0;
      else if (dl_rise)                           checksum <= '0;
      else if ((state == WAIT) && bus.sdr_ack)    checksum <= checksum + sdr_din_q;
   end
`endif

endmodule

// File: tb/tb_rom_dl_packer.sv
// Scoreboard bench for rom_dl_packer: expected writes are queued at stimulus time and
// compared by a monitor whenever the DUT raises sdr_we.
module tb_rom_dl_packer;
   import rom_dl_pkg::*;

   typedef struct packed {
      logic [23:0] addr;
      logic [15:0] data;
   } exp_t;

   logic clk_sys = 1'b0;
   logic reset;
   logic rom_download;
   logic rom_loaded, overflow, busy;
`ifdef ROM_DL_CHECKSUM_EN
   word_t checksum;
`endif

   rom_dl_packer_if #(.ADDR_W(25)) bus ();

   rom_dl_packer #(
      .ADDR_W     (25),
      .FIFO_DEPTH (4),
      .PAD_BYTE   (8'hFF)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .rom_download (rom_download),
      .bus          (bus),
      .rom_loaded   (rom_loaded),
      .overflow     (overflow),
      .busy         (busy)
`ifdef ROM_DL_CHECKSUM_EN
      ,
      .checksum     (checksum)
`endif
   );

   always #5 clk_sys = ~clk_sys;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   ack_cnt = 0;
   int   ack_wait = 0;
   int   ack_delay = 3;
   logic ack_en = 1'b0;
   logic prev_we = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_w(input logic [23:0] a, input logic [15:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
      @(negedge clk_sys);
      bus.ioctl_wr   = 1'b1;
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      @(negedge clk_sys);
      bus.ioctl_wr   = 1'b0;
   endtask

   task automatic start_dl();
      @(negedge clk_sys);
      rom_download = 1'b1;
      @(negedge clk_sys);
   endtask

   // Returns at the first negedge after the target number of acks has been accepted.
   task automatic wait_acks(input int target, input string name);
      bit done = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk_sys);
         if (ack_cnt >= target) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: acks %0d expected %0d", name, ack_cnt, target);
      end
   endtask

   // Monitor: each new write request is compared against the scoreboard head.
   always @(negedge clk_sys) begin
      if (bus.sdr_we && !prev_we) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %h data %h with nothing expected", bus.sdr_addr, bus.sdr_din);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("write_addr", 32'(bus.sdr_addr), 32'(e.addr));
            check("write_data", 32'(bus.sdr_din), 32'(e.data));
         end
      end
      prev_we = bus.sdr_we;
   end

   // SDRAM responder: one-cycle ack after ack_delay cycles of sdr_we.
   always @(negedge clk_sys) begin
      if (bus.sdr_ack) begin
         bus.sdr_ack = 1'b0;
         ack_wait    = 0;
      end else if (bus.sdr_we && ack_en) begin
         ack_wait++;
         if (ack_wait >= ack_delay) bus.sdr_ack = 1'b1;
      end else begin
         ack_wait = 0;
      end
   end

   always @(posedge clk_sys) begin
      if (!reset && bus.sdr_we && bus.sdr_ack) ack_cnt++;
   end

   initial begin
      int base;
      reset          = 1'b1;
      rom_download   = 1'b0;
      bus.ioctl_wr   = 1'b0;
      bus.ioctl_addr = '0;
      bus.ioctl_dout = '0;
      bus.sdr_ack    = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("rst_sdr_we", 32'(bus.sdr_we), 32'd0);
      check("rst_sdr_addr", 32'(bus.sdr_addr), 32'd0);
      check("rst_sdr_din", 32'(bus.sdr_din), 32'd0);
      check("rst_rom_loaded", 32'(rom_loaded), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // Two full words, ack after 3 cycles
      ack_en    = 1'b1;
      ack_delay = 3;
      start_dl();
      expect_w(24'd0, 16'h1234);
      expect_w(24'd1, 16'h5678);
      wr_byte(25'd0, 8'h12);
      wr_byte(25'd1, 8'h34);
      wr_byte(25'd2, 8'h56);
      wr_byte(25'd3, 8'h78);
      @(negedge clk_sys);
      rom_download = 1'b0;
      check("t1_busy_during", 32'(busy), 32'd1);
      wait_acks(2, "t1");
      check("t1_loaded_not_yet", 32'(rom_loaded), 32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);
      @(negedge clk_sys);
      check("t1_loaded", 32'(rom_loaded), 32'd1);

      // Unpaired even bytes get padded; new download clears rom_loaded
      start_dl();
      check("t5_loaded_cleared", 32'(rom_loaded), 32'd0);
      expect_w(24'd2, 16'hABFF);
      expect_w(24'd4, 16'hCDFF);
      wr_byte(25'd4, 8'hAB);
      wr_byte(25'd8, 8'hCD);
      @(negedge clk_sys);
      rom_download = 1'b0;
      wait_acks(4, "t2");
      check("t2_overflow", 32'(overflow), 32'd0);
      @(negedge clk_sys);
      check("t5_loaded_again", 32'(rom_loaded), 32'd1);
      check("t2_sb_empty", 32'(sb.size()), 32'd0);

      // Stalled SDRAM: 4 words in FIFO plus 1 in flight, rest dropped
      ack_en = 1'b0;
      start_dl();
      for (int i = 0; i < 12; i++) begin
         if (i < 5) expect_w(24'(24'h40 + i), {8'(i), 8'(8'hA0 + i)});
         wr_byte(25'(2 * (32'h40 + i)), 8'(i));
         wr_byte(25'(2 * (32'h40 + i) + 1), 8'(8'hA0 + i));
      end
      @(negedge clk_sys);
      check("t3_overflow", 32'(overflow), 32'd1);
      check("t3_sdr_we_held", 32'(bus.sdr_we), 32'd1);
      check("t3_sb_left", 32'(sb.size()), 32'd4);
      rom_download = 1'b0;
      ack_delay    = 1;
      ack_en       = 1'b1;
      wait_acks(9, "t3");
      repeat (2) @(negedge clk_sys);
      check("t3_sb_empty", 32'(sb.size()), 32'd0);
      check("t3_loaded", 32'(rom_loaded), 32'd1);
      check("t3_overflow_sticky", 32'(overflow), 32'd1);

`ifdef ROM_DL_CHECKSUM_EN
      // Checksum wraps: 0xFFFF + 0x0002 = 0x0001
      start_dl();
      check("t6_cksum_clear", 32'(checksum), 32'd0);
      expect_w(24'd0, 16'hFFFF);
      expect_w(24'd1, 16'h0002);
      wr_byte(25'd0, 8'hFF);
      wr_byte(25'd1, 8'hFF);
      wr_byte(25'd2, 8'h00);
      wr_byte(25'd3, 8'h02);
      @(negedge clk_sys);
      rom_download = 1'b0;
      wait_acks(11, "t6");
      check("t6_checksum", 32'(checksum), 32'h0001);
`endif

      // Reset while waiting with 2 words queued
      ack_en = 1'b0;
      start_dl();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) expect_w(24'(24'h10 + i), {8'(8'h50 + i), 8'(8'h60 + i)});
         wr_byte(25'(2 * (32'h10 + i)), 8'(8'h50 + i));
         wr_byte(25'(2 * (32'h10 + i) + 1), 8'(8'h60 + i));
      end
      @(negedge clk_sys);
      check("t4_we_before", 32'(bus.sdr_we), 32'd1);
      check("t4_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      #1;
      check("t4_we_async", 32'(bus.sdr_we), 32'd0);
      check("t4_addr_async", 32'(bus.sdr_addr), 32'd0);
      check("t4_loaded_async", 32'(rom_loaded), 32'd0);
      check("t4_busy_async", 32'(busy), 32'd0);
      rom_download = 1'b0;
      repeat (3) @(negedge clk_sys);
      reset  = 1'b0;
      ack_en = 1'b1;
      base   = ack_cnt;
      repeat (20) @(negedge clk_sys);
      check("t4_no_writes", 32'(ack_cnt - base), 32'd0);
      check("t4_loaded", 32'(rom_loaded), 32'd0);
      check("t4_sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
